// File: rtl/spi_master_tx.sv
// SPI master, CPHA=0, MSB first: one frame of 1..DWIDTH bits per start request.
// Every output is registered; busy covers the frame plus a CLKDIV-cycle inter-frame gap.
module spi_master_tx #(
  parameter int   DWIDTH = 32,
  parameter logic CPOL   = 1'b1,
  parameter int   CLKDIV = 4,
  localparam int  NBW    = $clog2(DWIDTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DWIDTH-1:0] tx_data,
  input  logic [NBW-1:0]    nbits,
  output logic              busy,
  output logic              done,
  output logic [DWIDTH-1:0] rx_data,
  output logic              spi_ss_n,
  output logic              spi_sclk,
  output logic              spi_mosi,
  input  logic              spi_miso
);

  if (CLKDIV < 1) begin : g_bad_clkdiv
    $error("spi_master_tx: CLKDIV must be 1 or more");
  end
  if (DWIDTH < 2) begin : g_bad_dwidth
    $error("spi_master_tx: DWIDTH must be 2 or more");
  end

  localparam int CW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKDIV - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_LEAD  = 3'd2;
  localparam logic [2:0] S_TRAIL = 3'd3;
  localparam logic [2:0] S_HOLD  = 3'd4;
  localparam logic [2:0] S_GAP   = 3'd5;

  logic [2:0]        state;
  logic [CW-1:0]     cnt;
  logic              cnt_end;
  logic [NBW-1:0]    bits_left;
  logic [NBW-1:0]    n_eff;
  logic [DWIDTH-1:0] tx_sh;
  logic [DWIDTH-1:0] tx_next;
  logic [DWIDTH-1:0] tx_aligned;
  logic [DWIDTH-1:0] rx_sh;

  always_comb begin
    n_eff = nbits;
    if (nbits == '0 || nbits > NBW'(DWIDTH)) n_eff = NBW'(DWIDTH);
  end

  // Left-align the payload so the first bit to send is always the shifter MSB.
  assign tx_aligned = tx_data << (NBW'(DWIDTH) - n_eff);
  assign tx_next    = tx_sh << 1;
  assign cnt_end    = (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bits_left <= '0;
      tx_sh     <= '0;
      rx_sh     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rx_data   <= '0;
      spi_ss_n  <= 1'b1;
      spi_sclk  <= CPOL;
      spi_mosi  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state != S_IDLE) cnt <= cnt_end ? '0 : cnt + CW'(1);
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_SETUP;
            cnt       <= '0;
            busy      <= 1'b1;
            spi_ss_n  <= 1'b0;
            tx_sh     <= tx_aligned;
            spi_mosi  <= tx_aligned[DWIDTH-1];
            bits_left <= n_eff;
            rx_sh     <= '0;
          end
        end
        S_SETUP: begin
          if (cnt_end) begin
            state    <= S_LEAD;
            spi_sclk <= ~CPOL;
          end
        end
        S_LEAD: begin
          if (cnt_end) begin
            state     <= S_TRAIL;
            spi_sclk  <= CPOL;
            rx_sh     <= {rx_sh[DWIDTH-2:0], spi_miso};
            bits_left <= bits_left - NBW'(1);
            // The last bit stays on mosi until slave select is released.
            if (bits_left != NBW'(1)) begin
              tx_sh    <= tx_next;
              spi_mosi <= tx_next[DWIDTH-1];
            end
          end
        end
        S_TRAIL: begin
          if (cnt_end) begin
            if (bits_left == '0) begin
              state <= S_HOLD;
            end else begin
              state    <= S_LEAD;
              spi_sclk <= ~CPOL;
            end
          end
        end
        S_HOLD: begin
          if (cnt_end) begin
            state    <= S_GAP;
            spi_ss_n <= 1'b1;
            spi_mosi <= 1'b0;
            done     <= 1'b1;
            rx_data  <= rx_sh;
          end
        end
        S_GAP: begin
          if (cnt_end) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
